// File: rtl/bus_arbiter.sv
// Arbitrates the core memory port between the LSU (m0) and IFU (m1), one transaction at a time.
// Optional macro ARB_RR_EN selects round-robin arbitration; default is fixed LSU priority.
module bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_err_o,
    input  logic                m1_req_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic                m1_flush_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_err_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic                s_gnt_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic                hold_req_o
);
    localparam int unsigned     CntW    = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                drop_q, drop_d;

    logic              sel;
    logic              any_req;
    logic              flush;
    logic              timeout;
    logic              rsp;
    logic              rsp_err;
    logic              deliver;
    logic [DATA_W-1:0] rdata_pass;

    assign any_req = m0_req_i | m1_req_i;
    assign flush   = m1_flush_i & owner_q;
    assign timeout = (cnt_q == CntLast);

`ifdef ARB_RR_EN
    // Master preferred on a tie; LSU out of reset, flips to the other master on every grant.
    logic prio_q, prio_d;

    always_comb begin
        sel    = (m0_req_i & m1_req_i) ? prio_q : m1_req_i;
        prio_d = prio_q;
        if ((state_q == StIdle) && any_req) begin
            prio_d = ~sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign sel = ~m0_req_i;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        rsp     = 1'b0;
        rsp_err = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d = sel;
                    we_d    = ~sel & m0_we_i;
                    addr_d  = sel ? m1_addr_i : m0_addr_i;
                    wdata_d = sel ? '0 : m0_wdata_i;
                    wstrb_d = sel ? '0 : m0_wstrb_i;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                if (flush && !s_gnt_i) begin
                    state_d = StIdle;
                end else if (timeout) begin
                    state_d = StIdle;
                    rsp     = 1'b1;
                    rsp_err = 1'b1;
                end else if (s_gnt_i) begin
                    state_d = StRsp;
                    drop_d  = flush;
                end
            end
            StRsp: begin
                cnt_d  = cnt_q + 1'b1;
                drop_d = drop_q | flush;
                if (s_rvalid_i) begin
                    state_d = StIdle;
                    rsp     = 1'b1;
                end else if (timeout) begin
                    state_d = StIdle;
                    rsp     = 1'b1;
                    rsp_err = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // A flushed IFU transaction still completes on the bus but is swallowed here.
    assign deliver    = rsp & ~(drop_q | flush);
    assign rdata_pass = (deliver & ~rsp_err) ? s_rdata_i : '0;

    // IDLE-state outputs are combinational on the request inputs, so mask them during reset.
    assign m0_gnt_o    = rst_n & (state_q == StIdle) & any_req & ~sel;
    assign m1_gnt_o    = rst_n & (state_q == StIdle) & any_req & sel;
    assign hold_req_o  = rst_n & ((state_q != StIdle) | any_req);

    assign m0_rvalid_o = deliver & ~owner_q;
    assign m0_err_o    = deliver & ~owner_q & rsp_err;
    assign m0_rdata_o  = owner_q ? '0 : rdata_pass;
    assign m1_rvalid_o = deliver & owner_q;
    assign m1_err_o    = deliver & owner_q & rsp_err;
    assign m1_rdata_o  = owner_q ? rdata_pass : '0;

    assign s_req_o   = (state_q == StReq);
    assign s_we_o    = s_req_o & we_q;
    assign s_addr_o  = s_req_o ? addr_q : '0;
    assign s_wdata_o = s_req_o ? wdata_q : '0;
    assign s_wstrb_o = s_req_o ? wstrb_q : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus queues expected gnt/rvalid events with their cycle,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_bus_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [3:0]    m0_wstrb;
    logic          m0_gnt, m0_rvalid, m0_err;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_flush;
    logic [AW-1:0] m1_addr;
    logic          m1_gnt, m1_rvalid, m1_err;
    logic [DW-1:0] m1_rdata;
    logic          s_req, s_we, s_gnt, s_rvalid;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [3:0]    s_wstrb;
    logic          hold_req;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_wstrb_i(m0_wstrb), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_flush_i(m1_flush), .m1_gnt_o(m1_gnt),
        .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_wstrb_o(s_wstrb), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .hold_req_o(hold_req)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        bit          is_rsp;
        bit          m;
        logic [31:0] rdata;
        bit          err;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic expect_ev(input string name, input bit is_rsp, input bit m,
                             input logic [31:0] rdata, input bit err, input int at);
        exp_t e;
        e.name = name; e.is_rsp = is_rsp; e.m = m; e.rdata = rdata; e.err = err; e.at = at;
        sb.push_back(e);
    endtask

    task automatic mon_event(input bit is_rsp, input bit m, input logic [31:0] rdata,
                             input bit err);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got rsp=%0d m%0d cyc %0d rdata %h err %0d, required none",
                     is_rsp, m, cyc, rdata, err);
        end else begin
            e = sb.pop_front();
            if (e.is_rsp != is_rsp || e.m != m || e.at != cyc ||
                (is_rsp && (e.rdata !== rdata || e.err != err))) begin
                errors++;
                $display("FAIL %s: got rsp=%0d m%0d cyc %0d rdata %h err %0d, required rsp=%0d m%0d cyc %0d rdata %h err %0d",
                         e.name, is_rsp, m, cyc, rdata, err, e.is_rsp, e.m, e.at, e.rdata, e.err);
            end
        end
    endtask

    // Monitor: at most one gnt/rvalid event can be visible per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (m0_gnt)    mon_event(1'b0, 1'b0, '0, 1'b0);
            if (m1_gnt)    mon_event(1'b0, 1'b1, '0, 1'b0);
            if (m0_rvalid) mon_event(1'b1, 1'b0, m0_rdata, m0_err);
            if (m1_rvalid) mon_event(1'b1, 1'b1, m1_rdata, m1_err);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has raised the winner's request in the current IDLE cycle.
    task automatic serve(input string name, input bit m, input logic [31:0] rdata);
        expect_ev({name, ".gnt"}, 1'b0, m, '0, 1'b0, cyc);
        tick();
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
        s_gnt = 1'b1;
        tick();
        s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = rdata;
        expect_ev({name, ".rsp"}, 1'b1, m, rdata, 1'b0, cyc);
        tick();
        s_rvalid = 1'b0; s_rdata = '0;
    endtask

    initial begin
        int t0;
        bit w;
        rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_req = 1'b1; m1_addr = '0; m1_flush = 1'b0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;

        // Reset: outputs quiet even with both requests raised.
        repeat (2) @(posedge clk);
        #1;
        check("rst.gnt", {m0_gnt, m1_gnt}, 0);
        check("rst.hold", hold_req, 0);
        check("rst.s_req", {s_req, s_we, s_addr}, 0);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.hold", hold_req, 0);

        // 1: IFU fetch, slave grants next cycle, responds two cycles after that.
        tick();
        m1_req = 1'b1; m1_addr = 32'h8000_0000; t0 = cyc;
        expect_ev("t1.gnt", 1'b0, 1'b1, '0, 1'b0, t0);
        @(negedge clk);
        check("t1.hold", hold_req, 1);
        tick();
        m1_req = 1'b0; m1_addr = '0; s_gnt = 1'b1;
        @(negedge clk);
        check("t1.s_req", s_req, 1);
        check("t1.s_addr", s_addr, 64'h8000_0000);
        check("t1.s_we", {s_we, s_wstrb}, 0);
        tick();
        s_gnt = 1'b0;
        tick();
        s_rvalid = 1'b1; s_rdata = 32'h0000_0013;
        expect_ev("t1.rsp", 1'b1, 1'b1, 32'h0000_0013, 1'b0, t0 + 3);
        tick();
        s_rvalid = 1'b0; s_rdata = '0;

        // 2: both request together four times; the loser stays pending afterwards.
        for (int k = 0; k < 4; k++) begin
            m0_req = 1'b1; m0_addr = 32'h100 + k;
            m1_req = 1'b1; m1_addr = 32'h200 + k;
`ifdef ARB_RR_EN
            w = k[0];
`else
            w = 1'b0;
`endif
            serve($sformatf("t2.r%0d", k), w, 32'hA0 + k);
        end
`ifdef ARB_RR_EN
        serve("t2.left", 1'b0, 32'hAF);
`else
        serve("t2.left", 1'b1, 32'hAF);
`endif

        // 3: LSU write; later master-side changes must not reach the slave fields.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1000; m0_wdata = 32'hDEAD_BEEF;
        m0_wstrb = 4'hF;
        expect_ev("t3.gnt", 1'b0, 1'b0, '0, 1'b0, cyc);
        tick();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h2222; m0_wdata = 32'h1234_5678;
        m0_wstrb = 4'h3;
        for (int i = 0; i < 2; i++) begin
            s_gnt = (i == 1);
            @(negedge clk);
            check($sformatf("t3.s_req%0d", i), {s_req, s_we}, 2'b11);
            check($sformatf("t3.s_addr%0d", i), s_addr, 64'h1000);
            check($sformatf("t3.s_wdata%0d", i), s_wdata, 64'hDEAD_BEEF);
            check($sformatf("t3.s_wstrb%0d", i), s_wstrb, 64'hF);
            tick();
        end
        s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = '0;
        expect_ev("t3.rsp", 1'b1, 1'b0, '0, 1'b0, cyc);
        @(negedge clk);
        check("t3.s_req_rsp", s_req, 0);
        tick();
        s_rvalid = 1'b0;
        m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;

        // 4: slave never grants -> error response TIMEOUT cycles after the grant.
        m0_req = 1'b1; m0_addr = 32'h40; t0 = cyc;
        expect_ev("t4.gnt", 1'b0, 1'b0, '0, 1'b0, t0);
        expect_ev("t4.tmo", 1'b1, 1'b0, '0, 1'b1, t0 + TO);
        tick();
        m0_req = 1'b0; m0_addr = '0;
        s_rdata = 32'hFFFF_FFFF;
        while (cyc < t0 + TO + 1) tick();
        @(negedge clk);
        check("t4.s_req_after", s_req, 0);
        check("t4.hold_after", hold_req, 0);
        s_rdata = '0;

        // 5a: IFU flush while still waiting for the slave grant.
        tick();
        m1_req = 1'b1; m1_addr = 32'h8000_0100;
        expect_ev("t5a.gnt", 1'b0, 1'b1, '0, 1'b0, cyc);
        tick();
        m1_req = 1'b0; m1_flush = 1'b1;
        tick();
        m1_flush = 1'b0;
        @(negedge clk);
        check("t5a.s_req", s_req, 0);
        check("t5a.hold", hold_req, 0);

        // 5b: IFU flush while waiting for the response; response is swallowed.
        tick();
        m1_req = 1'b1; m1_addr = 32'h8000_0104;
        expect_ev("t5b.gnt", 1'b0, 1'b1, '0, 1'b0, cyc);
        tick();
        m1_req = 1'b0; s_gnt = 1'b1;
        tick();
        s_gnt = 1'b0; m1_flush = 1'b1;
        tick();
        m1_flush = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h55;
        @(negedge clk);
        check("t5b.m1_rvalid", m1_rvalid, 0);
        tick();
        s_rvalid = 1'b0; s_rdata = '0;
        @(negedge clk);
        check("t5b.hold_idle", hold_req, 0);
        tick();
        m1_req = 1'b1; m1_addr = 32'h8000_0108;
        serve("t5b.next", 1'b1, 32'h77);

        // 6: asynchronous reset in RSP, then the pending IFU request is served.
        m1_req = 1'b1; m1_addr = 32'h8000_0200;
        expect_ev("t6.gnt", 1'b0, 1'b1, '0, 1'b0, cyc);
        tick();
        m1_req = 1'b0; s_gnt = 1'b1;
        tick();
        s_gnt = 1'b0;
        #2;
        rst_n = 1'b0; m1_req = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h66;
        #1;
        check("t6.ctl", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, s_req, s_we,
                         hold_req, s_wstrb}, 0);
        check("t6.rdata", {m0_rdata, m1_rdata}, 0);
        check("t6.s_bus", {s_addr, s_wdata}, 0);
        tick();
        s_rvalid = 1'b0; s_rdata = '0;
        @(negedge clk);
        check("t6.hold_rst", hold_req, 0);
        tick();
        rst_n = 1'b1;
        serve("t6.after", 1'b1, 32'h88);

        repeat (3) tick();
        check("sb.drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
